// File: rtl/uart_rx_cfg_if.sv
// Line and consumer-side signals of uart_rx_cfg.
// master = the receiver, slave = the byte-stream consumer (or a bench).
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_RX_SERIAL;
    logic [DATA_BITS-1:0] o_RX_DATA;
    logic                 o_RX_VALID;
    logic                 i_RX_READY;
    logic                 o_PARITY_ERR;
    logic                 o_FRAME_ERR;
    logic                 o_OVERRUN;
    logic                 o_BREAK;

    modport master (
        input  i_RX_SERIAL, i_RX_READY,
        output o_RX_DATA, o_RX_VALID, o_PARITY_ERR, o_FRAME_ERR, o_OVERRUN, o_BREAK
    );

    modport slave (
        output i_RX_SERIAL, i_RX_READY,
        input  o_RX_DATA, o_RX_VALID, o_PARITY_ERR, o_FRAME_ERR, o_OVERRUN, o_BREAK
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable-format oversampling UART receiver with majority voting and a valid/ready holding register.
// Define UART_RX_BREAK_EN to detect line breaks (BREAK_WAIT state, o_BREAK) instead of delivering them.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           i_CLK,
    input  logic           i_RESET,
    uart_rx_cfg_if.master  bus
);
    localparam int MAX_COUNT = CLK_FREQ / (BAUD_RATE * OVERSAMPLE) - 1;
    localparam int BW        = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
    localparam int TW        = $clog2(OVERSAMPLE);
    localparam int M         = OVERSAMPLE / 2;

    localparam logic [BW-1:0] BAUD_MAX = BW'(MAX_COUNT);
    localparam logic [TW-1:0] T_LO     = TW'(M - 1);
    localparam logic [TW-1:0] T_MID    = TW'(M);
    localparam logic [TW-1:0] T_HI     = TW'(M + 1);
    localparam logic [TW-1:0] T_END    = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY == 2);

`ifdef UART_RX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`endif

    state_t               state, state_nxt;
    logic                 rx_meta, rx_sync;
    logic [BW-1:0]        baud_cnt;
    logic                 baud_en;
    logic [TW-1:0]        tick;
    logic                 smp_a, smp_b, maj, decide;
    logic [3:0]           bit_idx;
    logic                 stop_idx, last_stop;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, pe, fe;
    logic                 complete;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_q, ferr_q, ovr_q;
`ifdef UART_RX_BREAK_EN
    logic                 zero_run;
    logic [TW-1:0]        hi_cnt;
`endif

    assign baud_en   = (baud_cnt == BAUD_MAX);
    assign decide    = baud_en && (tick == T_HI);
    assign maj       = (smp_a & smp_b) | (smp_a & rx_sync) | (smp_b & rx_sync);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        case (state)
            IDLE:  if (baud_en && !rx_sync) state_nxt = START;
            START: if (decide) state_nxt = maj ? IDLE : DATA;
            DATA:  if (decide && bit_idx == LAST_BIT) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (decide) state_nxt = STOP;
            STOP: begin
                if (decide) begin
`ifdef UART_RX_BREAK_EN
                    // all-zero data/parity plus a zero first stop bit is a break, not a word
                    if (!stop_idx && !maj && zero_run) begin
                        state_nxt = BRK_WAIT;
                    end else if (last_stop) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
`else
                    if (last_stop) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
`endif
                end
            end
`ifdef UART_RX_BREAK_EN
            BRK_WAIT: if (baud_en && rx_sync && hi_cnt == T_LO) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            baud_cnt <= '0;
            tick     <= '0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef UART_RX_BREAK_EN
            zero_run <= 1'b1;
            hi_cnt   <= '0;
`endif
        end else begin
            rx_meta  <= bus.i_RX_SERIAL;
            rx_sync  <= rx_meta;
            baud_cnt <= baud_en ? '0 : baud_cnt + 1'b1;

            if (state == IDLE) begin
                tick     <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                par_acc  <= 1'b0;
                pe       <= 1'b0;
                fe       <= 1'b0;
`ifdef UART_RX_BREAK_EN
                zero_run <= 1'b1;
`endif
            end else if (baud_en) begin
                tick <= (tick == T_END) ? '0 : tick + 1'b1;
                if (tick == T_LO)  smp_a <= rx_sync;
                if (tick == T_MID) smp_b <= rx_sync;
            end

            if (decide) begin
                case (state)
                    DATA: begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ maj;
                        bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_BREAK_EN
                        zero_run <= zero_run & ~maj;
`endif
                    end
                    PAR: begin
                        pe <= ((par_acc ^ maj) != ODD);
`ifdef UART_RX_BREAK_EN
                        zero_run <= zero_run & ~maj;
`endif
                    end
                    STOP: begin
                        fe       <= fe | ~maj;
                        stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end

`ifdef UART_RX_BREAK_EN
            if (state != BRK_WAIT) hi_cnt <= '0;
            else if (baud_en)      hi_cnt <= rx_sync ? hi_cnt + 1'b1 : '0;
`endif

            // the consumer may free the register in the very cycle a word completes
            if (complete) begin
                if (!valid_q || bus.i_RX_READY) begin
                    data_q  <= shreg;
                    perr_q  <= pe;
                    ferr_q  <= fe | ~maj;
                    valid_q <= 1'b1;
                    if (valid_q) ovr_q <= 1'b0;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.i_RX_READY) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
        end
    end

    assign bus.o_RX_DATA    = data_q;
    assign bus.o_RX_VALID   = valid_q;
    assign bus.o_PARITY_ERR = perr_q;
    assign bus.o_FRAME_ERR  = ferr_q;
    assign bus.o_OVERRUN    = ovr_q;
`ifdef UART_RX_BREAK_EN
    assign bus.o_BREAK      = (state == BRK_WAIT);
`else
    assign bus.o_BREAK      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] ser;
    logic [2:0] rdy;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) if1 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();

    assign if0.i_RX_SERIAL = ser[0];
    assign if1.i_RX_SERIAL = ser[1];
    assign if2.i_RX_SERIAL = ser[2];
    assign if0.i_RX_READY  = rdy[0];
    assign if1.i_RX_READY  = rdy[1];
    assign if2.i_RX_READY  = rdy[2];

    uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u0 (.i_CLK(clk), .i_RESET(rst), .bus(if0));
    uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                  .DATA_BITS(7), .PARITY(1), .STOP_BITS(1))
        u1 (.i_CLK(clk), .i_RESET(rst), .bus(if1));
    uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
        u2 (.i_CLK(clk), .i_RESET(rst), .bus(if2));

    // accepted-word capture per instance, sampled mid-cycle
    int acc0 = 0, acc1 = 0, acc2 = 0, vh0 = 0;
    logic [31:0] d0 = '0, d1 = '0, d2 = '0;
    logic pe0 = 1'b0, pe1 = 1'b0, pe2 = 1'b0;
    logic fe0 = 1'b0, fe1 = 1'b0, fe2 = 1'b0;

    always @(negedge clk) begin
        if (if0.o_RX_VALID) vh0 <= vh0 + 1;
        if (if0.o_RX_VALID && if0.i_RX_READY) begin
            acc0 <= acc0 + 1; d0 <= 32'(if0.o_RX_DATA); pe0 <= if0.o_PARITY_ERR; fe0 <= if0.o_FRAME_ERR;
        end
    end
    always @(negedge clk) begin
        if (if1.o_RX_VALID && if1.i_RX_READY) begin
            acc1 <= acc1 + 1; d1 <= 32'(if1.o_RX_DATA); pe1 <= if1.o_PARITY_ERR; fe1 <= if1.o_FRAME_ERR;
        end
    end
    always @(negedge clk) begin
        if (if2.o_RX_VALID && if2.i_RX_READY) begin
            acc2 <= acc2 + 1; d2 <= 32'(if2.o_RX_DATA); pe2 <= if2.o_PARITY_ERR; fe2 <= if2.o_FRAME_ERR;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bits[0] goes on the line first; each bit lasts 16 clocks
    task automatic send(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ser[which] = bits[i];
            cyc(16);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ser = 3'b111;
        rdy = 3'b111;
        cyc(4);
        check("rst_valid0", 32'(if0.o_RX_VALID), 0);
        check("rst_data0",  32'(if0.o_RX_DATA), 0);
        check("rst_pe0",    32'(if0.o_PARITY_ERR), 0);
        check("rst_fe0",    32'(if0.o_FRAME_ERR), 0);
        check("rst_ovr0",   32'(if0.o_OVERRUN), 0);
        check("rst_brk0",   32'(if0.o_BREAK), 0);
        check("rst_valid1", 32'(if1.o_RX_VALID), 0);
        check("rst_valid2", 32'(if2.o_RX_VALID), 0);
        rst = 1'b0;
        cyc(20);

        // 8N1 0xA5
        send(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
        cyc(16);
        check("a5_count",  32'(acc0), 1);
        check("a5_vhigh",  32'(vh0), 1);
        check("a5_data",   d0, 32'hA5);
        check("a5_pe",     32'(pe0), 0);
        check("a5_fe",     32'(fe0), 0);
        check("a5_ovr",    32'(if0.o_OVERRUN), 0);

        // 7E1 0x03: data parity is 0, so parity bit 1 is an error
        send(1, {6'd0, 1'b1, 1'b1, 7'h03, 1'b0}, 10);
        cyc(16);
        check("par1_count", 32'(acc1), 1);
        check("par1_data",  d1, 32'h03);
        check("par1_pe",    32'(pe1), 1);
        send(1, {6'd0, 1'b1, 1'b0, 7'h03, 1'b0}, 10);
        cyc(16);
        check("par0_count", 32'(acc1), 2);
        check("par0_data",  d1, 32'h03);
        check("par0_pe",    32'(pe1), 0);
        check("par0_fe",    32'(fe1), 0);

        // 8N2 0x5A with second stop bit low
        send(2, {5'd0, 1'b0, 1'b1, 8'h5A, 1'b0}, 11);
        ser[2] = 1'b1;
        cyc(32);
        check("stop2_count", 32'(acc2), 1);
        check("stop2_data",  d2, 32'h5A);
        check("stop2_fe",    32'(fe2), 1);
        check("stop2_pe",    32'(pe2), 0);

        // overrun: 0x11 held, 0x22 dropped
        rdy[0] = 1'b0;
        send(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
        send(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
        cyc(16);
        check("ovr_valid", 32'(if0.o_RX_VALID), 1);
        check("ovr_data",  32'(if0.o_RX_DATA), 32'h11);
        check("ovr_flag",  32'(if0.o_OVERRUN), 1);
        rdy[0] = 1'b1;
        cyc(1);
        rdy[0] = 1'b0;
        check("ovr_clr_valid", 32'(if0.o_RX_VALID), 0);
        check("ovr_clr_flag",  32'(if0.o_OVERRUN), 0);
        check("ovr_acc",       32'(acc0), 2);
        check("ovr_acc_data",  d0, 32'h11);
        rdy[0] = 1'b1;

        // 4-clock low glitch, then a real frame
        ser[0] = 1'b0;
        cyc(4);
        ser[0] = 1'b1;
        cyc(40);
        check("glitch_none",  32'(acc0), 2);
        check("glitch_valid", 32'(if0.o_RX_VALID), 0);
        send(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10);
        cyc(16);
        check("post_glitch_count", 32'(acc0), 3);
        check("post_glitch_data",  d0, 32'h3C);

        // 0x00 with a 1-clock high spike at tick M of data bit 3
        send(0, 16'h0000, 4);
        ser[0] = 1'b0; cyc(9);
        ser[0] = 1'b1; cyc(1);
        ser[0] = 1'b0; cyc(6);
        send(0, {11'd0, 1'b1, 4'h0}, 5);
        cyc(16);
        check("spike_count", 32'(acc0), 4);
        check("spike_data",  d0, 32'h00);
        check("spike_fe",    32'(fe0), 0);

`ifdef UART_RX_BREAK_EN
        ser[0] = 1'b0;
        cyc(30 * 16);
        check("brk_high",  32'(if0.o_BREAK), 1);
        check("brk_nodlv", 32'(acc0), 4);
        check("brk_valid", 32'(if0.o_RX_VALID), 0);
        ser[0] = 1'b1;
        cyc(4);
        check("brk_hold", 32'(if0.o_BREAK), 1);
        cyc(16);
        check("brk_low", 32'(if0.o_BREAK), 0);
        send(0, {6'd0, 1'b1, 8'h42, 1'b0}, 10);
        cyc(16);
        check("brk_next_count", 32'(acc0), 5);
        check("brk_next_data",  d0, 32'h42);
`else
        send(0, {6'd0, 1'b0, 8'h00, 1'b0}, 10);
        ser[0] = 1'b1;
        cyc(32);
        check("brkframe_count", 32'(acc0), 5);
        check("brkframe_data",  d0, 32'h00);
        check("brkframe_fe",    32'(fe0), 1);
        check("brkframe_brk",   32'(if0.o_BREAK), 0);
        send(0, {6'd0, 1'b1, 8'h42, 1'b0}, 10);
        cyc(16);
        check("brk_next_count", 32'(acc0), 6);
        check("brk_next_data",  d0, 32'h42);
        check("brk_next_fe",    32'(fe0), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
